rca_nibble_sequencer: RTL

- Nibble-serial sequencer that adds two WIDTH-bit operands using the team's existing 4-bit carry-lookahead adder slice, one nibble per cycle.
- Registers the operands, drives the slice's a/b/cin inputs from that registered state, and consumes the slice's sum/cout.
- Chains the carry between nibbles and presents a WIDTH-bit result with a done pulse.
- The 4-bit adder is instantiated beside this block at the parent level and wired to the add_* ports.

---
 rtl/rca_nibble_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer
//   Adds two WIDTH-bit operands one nibble per cycle through an external 4-bit
//   adder slice. The slice sits beside this block at the parent level. This block
//   drives the slice from registered operand/carry state and collects its sum and
//   carry-out. The carry is chained from one nibble to the next. When the top
//   nibble finishes, the result is published with a one-cycle done pulse.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request a new addition (accepted in IDLE or DONE)
//   a, b, cin         operands and carry-in, captured on the accepted edge
//   busy              high while nibbles are being processed
//   done              one-cycle pulse when sum/cout hold a fresh result
//   sum, cout         registered result, stable until the next completion
//   add_a/add_b/add_cin   drive to the adder slice
//   add_sum/add_cout      return from the adder slice
module rca_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             carry;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_upd;
   logic             last;
   logic             accept;

   assign last   = (idx == LAST_IDX);
   // Start is honoured whenever the loop is not running, including the DONE
   // cycle, which gives back-to-back operation.
   assign accept = start && (state != RUN);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // Shadow with the current nibble merged in. On the last nibble this is the
   // complete result, so sum can be loaded in the same edge.
   always_comb begin
      shadow_upd = shadow;
      shadow_upd[{idx, 2'b00} +: 4] = add_sum;
   end

   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_reg[{idx, 2'b00} +: 4];
         add_b   = b_reg[{idx, 2'b00} +: 4];
         add_cin = carry;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         carry  <= 1'b0;
         shadow <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
         end else if (state == RUN) begin
            shadow <= shadow_upd;
            carry  <= add_cout;
            if (last) begin
               idx  <= '0;
               sum  <= shadow_upd;
               cout <= add_cout;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule
